inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage. Holds the program counter and fetches 32-bit words from instruction memory over a req/ack handshake. Presents each word with its PC to the instruction decoder through a valid/ready interface. Accepts branch/jump redirects from the execute path, including redirects that arrive while a memory access is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- NOP_INST, 32'h0000_0013, value driven on `inst` while no instruction is held (addi x0,x0,0)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  fetch address; stable while imem_req=1
- imem_ack  in  1  data valid this cycle; sampled only while imem_req=1
- imem_rdata  in  32  fetched word, qualified by imem_ack
- redirect  in  1  single-cycle pulse: next fetch from redirect_pc
- redirect_pc  in  32  redirect target
- inst_valid  out  1  inst/inst_pc hold a decodable instruction
- inst  out  32  instruction word to decoder
- inst_pc  out  32  address of inst
- inst_ready  in  1  decoder consumes inst when inst_valid=1
- misalign_err  out  1  sticky: a redirect target had bits [1:0]≠0
- fetch_cnt  out  32  count of delivered instructions (valid&ready), wraps at 2^32

## Operation
- Registers:
  - pc_q: next fetch address.
  - imem_addr: captured when a request is issued.
  - inst, inst_pc, fetch_cnt, misalign_err, state.
- States:
  - IDLE: post-reset. Unconditionally goes to FETCH on the first edge after rst deasserts, loading imem_addr←pc_q.
  - FETCH: imem_req=1.
    - On ack without redirect: inst←imem_rdata, inst_pc←imem_addr, pc_q←imem_addr+4 (mod 2^32); go to VALID.
    - On ack with redirect: discard data, pc_q←redirect_pc, imem_addr←redirect_pc; stay in FETCH.
    - On redirect without ack: pc_q←redirect_pc; go to DROP. imem_addr is unchanged.
  - DROP: imem_req=1 with the old imem_addr; data is discarded.
    - A redirect in DROP overwrites pc_q (last redirect wins).
    - On ack: imem_addr←pc_q (or redirect_pc if a redirect arrives in the same cycle); go to FETCH.
  - VALID: inst_valid=1, imem_req=0.
    - Redirect has priority over ready: drop the held instruction, pc_q←redirect_pc, imem_addr←redirect_pc; go to FETCH. fetch_cnt is not incremented.
    - Else, if inst_ready: fetch_cnt+1, imem_addr←pc_q; go to FETCH.
    - Else: hold inst and inst_pc unchanged.
  - HALT: entered when any accepted redirect has redirect_pc[1:0]≠0.
    - misalign_err←1; no requests are issued.
    - Exit only via rst.
    - If the misaligned redirect arrives in FETCH or DROP without ack, go to HALT only after the outstanding ack, so the handshake is never abandoned.
- inst outputs NOP_INST and inst_pc holds its last value whenever inst_valid=0.
- imem_req and inst_valid are decoded from state. They are never asserted together.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, imem_req=0, imem_addr=RESET_PC, pc_q=RESET_PC.
  - inst_valid=0, inst=NOP_INST, inst_pc=RESET_PC, misalign_err=0, fetch_cnt=0.
- Cycle 0 after deassert: IDLE. Cycle 1: imem_req=1, imem_addr=RESET_PC.
- Zero-wait memory (ack in the first req cycle): inst_valid is seen the next cycle.
  - With inst_ready=1: FETCH/VALID alternate, giving 1 instruction per 2 cycles.
- N wait states: inst_valid rises N+1 cycles after imem_req rises.
- A redirect in cycle t takes effect at edge t. The earliest request to the new target is cycle t+1 (FETCH/VALID), or the cycle after the outstanding ack (DROP).
- Reset asserted mid-request: imem_req drops combinationally with the state. Memory must tolerate an abandoned request on reset.

## Test plan
- Reset, then release with imem_ack tied to imem_req, rdata=addr^32'hA5A5A5A5, inst_ready=1.
  - Required: addresses 0, 4, 8 issued in cycles 1, 3, 5.
  - inst_pc = 0, 4, 8; inst = 32'hA5A5A5A5, 32'hA5A5A5A1, 32'hA5A5A5AD.
  - fetch_cnt=3 after the third handshake.
- Ack latency of 3 cycles.
  - Required: imem_req=1 and imem_addr=0 held for 4 cycles; inst_valid rises in cycle 5; no second request before then.
- inst_ready=0 for 4 cycles with inst_valid=1 (inst_pc=4).
  - Required: inst and inst_pc constant, imem_req=0, fetch_cnt unchanged.
  - Next request issues 1 cycle after ready rises, at addr 8.
- Redirect to 32'h100 two cycles into a 3-cycle-latency fetch of addr 8.
  - Required: imem_addr stays 8 until ack, and that data never appears on inst.
  - Next request is to 32'h100; first inst_pc delivered is 32'h100.
- Redirect to 32'h200 in VALID with inst_ready=1 in the same cycle.
  - Required: held instruction dropped, fetch_cnt unchanged, next request is to 32'h200.
- Redirect to 32'h102.
  - Required: misalign_err=1, no further imem_req until rst.
  - rst clears misalign_err to 0 and restarts fetch at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack, decoder valid/ready, execute redirect.
// Combinational wiring only; no added latency.
// Memory side holds req until ack; decoder side holds valid until ready.
//
// Ports (master = fetch unit, slave = memory/decoder/execute environment):
//   imem_req/imem_addr  -> memory      imem_ack/imem_rdata <- memory
//   redirect/redirect_pc <- execute    inst_valid/inst/inst_pc -> decoder
//   inst_ready <- decoder              misalign_err/fetch_cnt -> status
interface inst_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        misalign_err;
   logic [31:0] fetch_cnt;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      input  redirect, redirect_pc,
      output inst_valid, inst, inst_pc,
      input  inst_ready,
      output misalign_err, fetch_cnt
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      output redirect, redirect_pc,
      input  inst_valid, inst, inst_pc,
      output inst_ready,
      input  misalign_err, fetch_cnt
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: holds the PC, fetches words over req/ack, hands them to decode.
// Latency: request one cycle after IDLE/VALID; word valid the cycle after ack.
// Backpressure: held instruction stays put while inst_ready=0; no new request meanwhile.
//
// Ports: clk, rst (async active-high); bus (inst_fetch_if.master) carrying the
// memory req/ack pair, execute redirect, decoder valid/ready and status outputs.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   inst_fetch_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DROP,
      S_VALID,
      S_HALT
   } state_t;

   state_t      state_q,     state_d;
   logic [31:0] pc_q,        pc_d;
   logic [31:0] addr_q,      addr_d;
   logic [31:0] inst_q,      inst_d;
   logic [31:0] inst_pc_q,   inst_pc_d;
   logic [31:0] cnt_q,       cnt_d;
   logic        err_q,       err_d;
   // A misaligned redirect arrived while a request was outstanding; the
   // handshake is finished first, then the stage halts.
   logic        halt_pend_q, halt_pend_d;

   logic        redir_bad;

   assign redir_bad = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         inst_q      <= NOP_INST;
         inst_pc_q   <= RESET_PC;
         cnt_q       <= 32'd0;
         err_q       <= 1'b0;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         inst_q      <= inst_d;
         inst_pc_q   <= inst_pc_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      inst_d      = inst_q;
      inst_pc_d   = inst_pc_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      halt_pend_d = halt_pend_q;

      bus.imem_req     = 1'b0;
      bus.inst_valid   = 1'b0;
      bus.imem_addr    = addr_q;
      bus.inst         = NOP_INST;
      bus.inst_pc      = inst_pc_q;
      bus.misalign_err = err_q;
      bus.fetch_cnt    = cnt_q;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            addr_d  = pc_q;
         end

         S_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ack) begin
               if (bus.redirect) begin
                  // Returned word belongs to the old path; refetch at target.
                  pc_d = bus.redirect_pc;
                  if (redir_bad) begin
                     state_d = S_HALT;
                     err_d   = 1'b1;
                  end else begin
                     addr_d = bus.redirect_pc;
                  end
               end else begin
                  inst_d    = bus.imem_rdata;
                  inst_pc_d = addr_q;
                  pc_d      = addr_q + 32'd4;
                  state_d   = S_VALID;
               end
            end else if (bus.redirect) begin
               // Address must stay stable until ack, so only pc_q moves.
               pc_d        = bus.redirect_pc;
               halt_pend_d = redir_bad;
               state_d     = S_DROP;
            end
         end

         S_DROP: begin
            bus.imem_req = 1'b1;
            if (bus.redirect) begin
               pc_d = bus.redirect_pc;
               if (redir_bad) begin
                  halt_pend_d = 1'b1;
               end
            end
            if (bus.imem_ack) begin
               halt_pend_d = 1'b0;
               if (halt_pend_q || redir_bad) begin
                  state_d = S_HALT;
                  err_d   = 1'b1;
               end else begin
                  addr_d  = bus.redirect ? bus.redirect_pc : pc_q;
                  state_d = S_FETCH;
               end
            end
         end

         S_VALID: begin
            bus.inst_valid = 1'b1;
            bus.inst       = inst_q;
            // Redirect wins over ready: the held word is on the wrong path.
            if (bus.redirect) begin
               pc_d = bus.redirect_pc;
               if (redir_bad) begin
                  state_d = S_HALT;
                  err_d   = 1'b1;
               end else begin
                  addr_d  = bus.redirect_pc;
                  state_d = S_FETCH;
               end
            end else if (bus.inst_ready) begin
               cnt_d   = cnt_q + 32'd1;
               addr_d  = pc_q;
               state_d = S_FETCH;
            end
         end

         S_HALT: begin
            state_d = S_HALT;
         end

         default: begin
            state_d = S_HALT;
         end
      endcase
   end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   mem_lat;
   int   wcnt;

   localparam logic [31:0] NOP = 32'h0000_0013;

   inst_fetch_if bus ();

   inst_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: acks after mem_lat wait cycles, data = addr ^ A5A5A5A5.
   always @(negedge clk) begin
      if (rst || !bus.imem_req) begin
         wcnt = 0;
         bus.imem_ack = 1'b0;
      end else begin
         bus.imem_ack = (wcnt >= mem_lat);
         wcnt = bus.imem_ack ? 0 : wcnt + 1;
      end
      bus.imem_rdata = bus.imem_addr ^ 32'hA5A5A5A5;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Leaves the bench in cycle 0 (IDLE), just after reset release.
   task automatic do_reset(input int lat);
      rst = 1'b1;
      mem_lat = lat;
      bus.redirect = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.inst_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(0);
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr); end
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.inst_valid); end
      checks++; if (bus.inst !== NOP) begin failures++; $display("FAIL reset_inst got=%h exp=%h", bus.inst, NOP); end
      checks++; if (bus.inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst_pc got=%h exp=0", bus.inst_pc); end
      checks++; if (bus.misalign_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.misalign_err); end
      checks++; if (bus.fetch_cnt !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.fetch_cnt); end
      // Asynchronous reset in the middle of a request drops imem_req at once.
      mem_lat = 3;
      tick();
      checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL reset_first_req got=%b exp=1", bus.imem_req); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_async_req got=%b exp=0", bus.imem_req); end
      tick();
   endtask

   task automatic test_stream();
      do_reset(0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4*k)) begin failures++; $display("FAIL stream_req k=%0d got req=%b addr=%h exp req=1 addr=%h", k, bus.imem_req, bus.imem_addr, 32'(4*k)); end
         checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL stream_excl k=%0d got valid=%b exp=0", k, bus.inst_valid); end
         tick();
         checks++; if (bus.inst_valid !== 1'b1 || bus.imem_req !== 1'b0) begin failures++; $display("FAIL stream_valid k=%0d got valid=%b req=%b exp 1/0", k, bus.inst_valid, bus.imem_req); end
         checks++; if (bus.inst_pc !== 32'(4*k)) begin failures++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, bus.inst_pc, 32'(4*k)); end
         checks++; if (bus.inst !== (32'(4*k) ^ 32'hA5A5A5A5)) begin failures++; $display("FAIL stream_inst k=%0d got=%h exp=%h", k, bus.inst, 32'(4*k) ^ 32'hA5A5A5A5); end
         checks++; if (bus.fetch_cnt !== 32'(k)) begin failures++; $display("FAIL stream_cnt k=%0d got=%0d exp=%0d", k, bus.fetch_cnt, k); end
      end
      tick();
      checks++; if (bus.fetch_cnt !== 32'd3) begin failures++; $display("FAIL stream_cnt_final got=%0d exp=3", bus.fetch_cnt); end
   endtask

   task automatic test_wait_states();
      do_reset(3);
      for (int c = 1; c <= 4; c++) begin
         tick();
         checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL wait_req c=%0d got req=%b addr=%h valid=%b exp 1/0/0", c, bus.imem_req, bus.imem_addr, bus.inst_valid); end
      end
      tick();
      checks++; if (bus.inst_valid !== 1'b1 || bus.imem_req !== 1'b0) begin failures++; $display("FAIL wait_valid got valid=%b req=%b exp 1/0", bus.inst_valid, bus.imem_req); end
      checks++; if (bus.inst !== 32'hA5A5A5A5) begin failures++; $display("FAIL wait_inst got=%h exp=a5a5a5a5", bus.inst); end
   endtask

   task automatic test_backpressure();
      do_reset(0);
      tick();
      tick();
      tick();
      checks++; if (bus.imem_addr !== 32'h4) begin failures++; $display("FAIL bp_addr4 got=%h exp=4", bus.imem_addr); end
      bus.inst_ready = 1'b0;
      for (int c = 4; c <= 7; c++) begin
         tick();
         checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h4 || bus.inst !== 32'hA5A5A5A1) begin failures++; $display("FAIL bp_hold c=%0d got valid=%b pc=%h inst=%h exp 1/4/a5a5a5a1", c, bus.inst_valid, bus.inst_pc, bus.inst); end
         checks++; if (bus.imem_req !== 1'b0 || bus.fetch_cnt !== 32'd1) begin failures++; $display("FAIL bp_idle c=%0d got req=%b cnt=%0d exp 0/1", c, bus.imem_req, bus.fetch_cnt); end
      end
      bus.inst_ready = 1'b1;
      tick();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.fetch_cnt !== 32'd2) begin failures++; $display("FAIL bp_release got req=%b addr=%h cnt=%0d exp 1/8/2", bus.imem_req, bus.imem_addr, bus.fetch_cnt); end
   endtask

   task automatic test_redirect_in_fetch();
      do_reset(0);
      tick();
      tick();
      tick();
      tick();
      mem_lat = 3;
      tick();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin failures++; $display("FAIL rf_start got req=%b addr=%h exp 1/8", bus.imem_req, bus.imem_addr); end
      tick();
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h100;
      tick();
      bus.redirect = 1'b0;
      for (int c = 7; c <= 8; c++) begin
         checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.inst !== NOP) begin failures++; $display("FAIL rf_drop c=%0d got req=%b addr=%h inst=%h exp 1/8/nop", c, bus.imem_req, bus.imem_addr, bus.inst); end
         tick();
      end
      for (int c = 9; c <= 12; c++) begin
         checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rf_new c=%0d got req=%b addr=%h valid=%b exp 1/100/0", c, bus.imem_req, bus.imem_addr, bus.inst_valid); end
         tick();
      end
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 || bus.inst !== 32'hA5A5A4A5) begin failures++; $display("FAIL rf_deliver got valid=%b pc=%h inst=%h exp 1/100/a5a5a4a5", bus.inst_valid, bus.inst_pc, bus.inst); end
      checks++; if (bus.fetch_cnt !== 32'd2) begin failures++; $display("FAIL rf_cnt got=%0d exp=2", bus.fetch_cnt); end
   endtask

   task automatic test_redirect_in_valid();
      do_reset(0);
      tick();
      tick();
      checks++; if (bus.inst_valid !== 1'b1) begin failures++; $display("FAIL rv_valid got=%b exp=1", bus.inst_valid); end
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h200;
      tick();
      bus.redirect = 1'b0;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rv_req got req=%b addr=%h valid=%b exp 1/200/0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
      checks++; if (bus.fetch_cnt !== 32'd0) begin failures++; $display("FAIL rv_cnt got=%0d exp=0", bus.fetch_cnt); end
      tick();
      checks++; if (bus.inst_pc !== 32'h200 || bus.inst !== 32'hA5A5A7A5) begin failures++; $display("FAIL rv_deliver got pc=%h inst=%h exp 200/a5a5a7a5", bus.inst_pc, bus.inst); end
      tick();
      checks++; if (bus.fetch_cnt !== 32'd1 || bus.imem_addr !== 32'h204) begin failures++; $display("FAIL rv_next got cnt=%0d addr=%h exp 1/204", bus.fetch_cnt, bus.imem_addr); end
   endtask

   task automatic test_misalign();
      // Misaligned redirect while an instruction is held.
      do_reset(0);
      tick();
      tick();
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h102;
      tick();
      bus.redirect = 1'b0;
      for (int c = 3; c <= 10; c++) begin
         checks++; if (bus.misalign_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL ma_halt c=%0d got err=%b req=%b valid=%b exp 1/0/0", c, bus.misalign_err, bus.imem_req, bus.inst_valid); end
         tick();
      end
      // Misaligned redirect during a waited fetch: finish the handshake first.
      do_reset(3);
      tick();
      tick();
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h102;
      tick();
      bus.redirect = 1'b0;
      for (int c = 3; c <= 4; c++) begin
         checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.misalign_err !== 1'b0) begin failures++; $display("FAIL ma_drain c=%0d got req=%b addr=%h err=%b exp 1/0/0", c, bus.imem_req, bus.imem_addr, bus.misalign_err); end
         tick();
      end
      checks++; if (bus.imem_req !== 1'b0 || bus.misalign_err !== 1'b1) begin failures++; $display("FAIL ma_drain_halt got req=%b err=%b exp 0/1", bus.imem_req, bus.misalign_err); end
      tick();
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL ma_drain_stay got req=%b exp 0", bus.imem_req); end
      rst = 1'b1;
      #1;
      checks++; if (bus.misalign_err !== 1'b0 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL ma_rst got err=%b addr=%h exp 0/0", bus.misalign_err, bus.imem_addr); end
      tick();
      rst = 1'b0;
      mem_lat = 0;
      tick();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL ma_restart got req=%b addr=%h exp 1/0", bus.imem_req, bus.imem_addr); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      mem_lat = 0;
      bus.redirect = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.inst_ready = 1'b1;
      test_reset();
      test_stream();
      test_wait_states();
      test_backpressure();
      test_redirect_in_fetch();
      test_redirect_in_valid();
      test_misalign();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
